// File: rtl/start_seq_ctrl_if.sv
// start_seq_ctrl_if: control inputs and status outputs of the start sequencer
interface start_seq_ctrl_if;
    logic       start;
    logic       abort;
    logic       false_start;
    logic       fault_clr;
    logic [2:0] state;
    logic       ready_lamp;
    logic       set_lamp;
    logic       go_lamp;
    logic       busy;
    logic       done;
    logic       fault;
    modport master (
        output start, abort, false_start, fault_clr,
        input  state, ready_lamp, set_lamp, go_lamp, busy, done, fault
    );
    modport slave (
        input  start, abort, false_start, fault_clr,
        output state, ready_lamp, set_lamp, go_lamp, busy, done, fault
    );
endinterface

// File: rtl/start_seq_ctrl.sv
// start_seq_ctrl: READY/SET/GO race-start sequencer with abort and false-start fault
module start_seq_ctrl #(
    parameter int CNT_W     = 8,
    parameter int READY_CYC = 16,
    parameter int SET_CYC   = 16,
    parameter int GO_CYC    = 8
) (
    input logic clk,
    input logic rst_n,
    start_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        SET   = 3'd2,
        GO    = 3'd3,
        FAULT = 3'd4
    } state_t;
    localparam logic [CNT_W-1:0] READY_LD = CNT_W'(READY_CYC - 1);
    localparam logic [CNT_W-1:0] SET_LD   = CNT_W'(SET_CYC - 1);
    localparam logic [CNT_W-1:0] GO_LD    = CNT_W'(GO_CYC - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    // next state: abort beats false_start beats dwell expiry; done only on a natural GO exit
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    if (bus.start && !bus.abort) state_d = READY;
            READY:   state_d = bus.abort ? IDLE : bus.false_start ? FAULT : (cnt_q == '0) ? SET : READY;
            SET:     state_d = bus.abort ? IDLE : bus.false_start ? FAULT : (cnt_q == '0) ? GO : SET;
            GO: begin
                state_d = (bus.abort || cnt_q == '0) ? IDLE : GO;
                done_d  = !bus.abort && cnt_q == '0;
            end
            FAULT:   if (bus.fault_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? ((state_d == READY) ? READY_LD :
                                        (state_d == SET)   ? SET_LD   :
                                        (state_d == GO)    ? GO_LD    : '0)
                                     : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    // state, dwell counter and registered done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
    assign bus.state      = state_q;
    assign bus.ready_lamp = state_q == READY;
    assign bus.set_lamp   = state_q == SET;
    assign bus.go_lamp    = state_q == GO;
    assign bus.busy       = state_q == READY || state_q == SET || state_q == GO;
    assign bus.fault      = state_q == FAULT;
    assign bus.done       = done_q;
endmodule

// File: doc/start_seq_ctrl.md
START_SEQ_CTRL -- requirements
Module: start_seq_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 8, dwell counter width.
REQ-002 SHALL provide parameter READY_CYC, default 16, cycles spent in READY (legal 1..2^CNT_W).
REQ-003 SHALL provide parameter SET_CYC, default 16, cycles spent in SET (legal 1..2^CNT_W).
REQ-004 SHALL provide parameter GO_CYC, default 8, cycles spent in GO (legal 1..2^CNT_W).
REQ-005 SHALL provide port clk  input  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL provide port start  input  1  request to begin a sequence, sampled only in IDLE.
REQ-008 SHALL provide port abort  input  1  cancel the running sequence.
REQ-009 SHALL provide port false_start  input  1  early-movement sensor, meaningful in READY/SET.
REQ-010 SHALL provide port fault_clr  input  1  clears FAULT.
REQ-011 SHALL provide port state  output  3  current state encoding.
REQ-012 SHALL provide port ready_lamp, set_lamp, go_lamp  output  1 each  one-hot lamp drives.
REQ-013 SHALL provide port busy  output  1  high in READY, SET, GO.
REQ-014 SHALL provide port done  output  1  single-cycle completion pulse.
REQ-015 SHALL provide port fault  output  1  high while in FAULT.

Function
REQ-016 SHALL implement states IDLE=3'd0, READY=3'd1, SET=3'd2, GO=3'd3, FAULT=3'd4; codes 5-7 SHALL transition to IDLE on the next edge.
REQ-017 SHALL be Moore: lamps, busy, fault, state decoded from the state register only; ready_lamp=READY, set_lamp=SET, go_lamp=GO.
REQ-018 IDLE with start=1 at edge k SHALL enter READY at edge k; READY SHALL last exactly READY_CYC cycles, then SET.
REQ-019 SET SHALL last exactly SET_CYC cycles, then GO; GO SHALL last exactly GO_CYC cycles, then IDLE.
REQ-020 Each state entry SHALL load the dwell counter with duration-1; exit SHALL occur on the edge where the counter reads 0.
REQ-021 done SHALL be registered, high for exactly the first IDLE cycle following a natural GO exit, and never after abort or FAULT.
REQ-022 start SHALL be ignored in READY, SET, GO and FAULT (no restart, no counter reload).
REQ-023 false_start=1 in READY or SET SHALL move to FAULT on the next edge; false_start in IDLE or GO SHALL be ignored.
REQ-024 abort=1 in READY, SET or GO SHALL move to IDLE on the next edge, no done.
REQ-025 abort and false_start simultaneously high SHALL resolve to abort (IDLE).
REQ-026 FAULT SHALL hold until fault_clr=1, then IDLE on the next edge; abort and start SHALL not exit FAULT.
REQ-027 IDLE with start=1 and abort=1 on the same edge SHALL stay IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, counter=0, done=0, all lamps/busy/fault=0, independent of clk.
REQ-029 Reset asserted mid-sequence SHALL discard progress; after release, no output change until a new start.

Verification (READY_CYC=3, SET_CYC=2, GO_CYC=2)
REQ-030 start pulse at edge 0 -> ready_lamp cycles 0-2, set_lamp 3-4, go_lamp 5-6, IDLE and done=1 cycle 7 only, busy 0-6.
REQ-031 false_start=1 in second SET cycle -> FAULT next edge, fault=1, lamps 0, done never; fault_clr -> IDLE next edge.
REQ-032 abort and false_start both high in READY -> IDLE next edge, fault=0, done=0.
REQ-033 start held high throughout sequence -> one sequence only while busy; new READY begins on edge following done cycle if start still high.
REQ-034 rst_n low asynchronously during GO -> all outputs 0 without clock edge; after release with start=0, state stays 0.
REQ-035 start high while in FAULT for 5 cycles -> remains FAULT, fault=1.
